// File: rtl/decfhs_commit.sv
`timescale 1ns/1ps
// FHS payload deserializer: shifts 144 decoded bits into a shadow register and
// publishes the FHS fields only after the payload CRC verdict allows it.
module decfhs_commit #(
  parameter int unsigned CRC_TMO       = 4095,
  parameter int unsigned TMO_W         = 12,
  parameter bit          UPDATE_ON_ERR = 1'b0
) (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        i_dec_py_st_p,
  input  logic        i_daten,
  input  logic        i_dec_py_period,
  input  logic        i_py_datvalid_p,
  input  logic        i_pydecdatout,
  input  logic        i_rxfhs,
  input  logic        i_crc_done_p,
  input  logic        i_crc_ok,
  output logic [33:0] o_fhs_pbits,
  output logic [23:0] o_fhs_lap,
  output logic        o_fhs_eir,
  output logic [1:0]  o_fhs_sr,
  output logic [1:0]  o_fhs_sp,
  output logic [7:0]  o_fhs_uap,
  output logic [15:0] o_fhs_nap,
  output logic [23:0] o_fhs_cod,
  output logic [2:0]  o_fhs_lt_addr,
  output logic [27:2] o_fhs_clk,
  output logic [2:0]  o_fhs_psm,
  output logic        o_fhs_new_p,
  output logic        o_fhs_err_p,
  output logic [1:0]  o_fhs_errcode,
  output logic        o_fhs_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [7:0]       NBITS   = 8'd144;
  localparam logic [7:0]       LASTBIT = 8'd143;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(CRC_TMO);
  localparam bit               TMO_EN  = (CRC_TMO != 0);

  logic [1:0]       r_state;
  logic [143:0]     r_sh;
  logic [7:0]       r_bcnt;
  logic [TMO_W-1:0] r_tmo;
  logic             r_new_p;
  logic             r_err_p;
  logic [1:0]       r_errcode;
  logic [33:0]      r_pbits;
  logic [23:0]      r_lap;
  logic             r_eir;
  logic [1:0]       r_sr;
  logic [1:0]       r_sp;
  logic [7:0]       r_uap;
  logic [15:0]      r_nap;
  logic [23:0]      r_cod;
  logic [2:0]       r_lt_addr;
  logic [25:0]      r_clk;
  logic [2:0]       r_psm;

  logic       w_accept;
  logic [1:0] w_state_d;
  logic       w_clr;
  logic       w_commit;
  logic       w_new;
  logic       w_err;
  logic [1:0] w_code;

  assign w_accept = i_py_datvalid_p & i_daten & i_dec_py_period & i_rxfhs &
                    (r_state == ST_SHIFT) & (r_bcnt < NBITS);

  // A payload start always wins, so a restart never reports an error.
  always_comb begin
    w_state_d = r_state;
    w_clr     = 1'b0;
    w_commit  = 1'b0;
    w_new     = 1'b0;
    w_err     = 1'b0;
    w_code    = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (i_dec_py_st_p) begin
          w_state_d = ST_SHIFT;
          w_clr     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (i_dec_py_st_p) begin
          w_clr = 1'b1;
        end else if (i_crc_done_p) begin
          w_state_d = ST_IDLE;
          w_err     = 1'b1;
          w_code    = 2'd2;
        end else if (w_accept && (r_bcnt == LASTBIT)) begin
          w_state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_dec_py_st_p) begin
          w_state_d = ST_SHIFT;
          w_clr     = 1'b1;
        end else if (i_crc_done_p) begin
          w_state_d = ST_IDLE;
          if (i_crc_ok) begin
            w_commit = 1'b1;
            w_new    = 1'b1;
          end else begin
            w_commit = UPDATE_ON_ERR;
            w_err    = 1'b1;
            w_code   = 2'd1;
          end
        end else if (TMO_EN && (r_tmo == TMO_LIM)) begin
          w_state_d = ST_IDLE;
          w_err     = 1'b1;
          w_code    = 2'd3;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_state   <= ST_IDLE;
      r_sh      <= '0;
      r_bcnt    <= '0;
      r_tmo     <= '0;
      r_new_p   <= 1'b0;
      r_err_p   <= 1'b0;
      r_errcode <= 2'd0;
    end else begin
      r_state <= w_state_d;
      r_new_p <= w_new;
      r_err_p <= w_err;
      if (w_new || w_err) r_errcode <= w_code;
      if (w_accept) r_sh <= {i_pydecdatout, r_sh[143:1]};
      if (w_clr) begin
        r_bcnt <= '0;
        r_tmo  <= '0;
      end else begin
        if (w_accept) r_bcnt <= r_bcnt + 8'd1;
        if (r_state == ST_WAIT) r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

  // Reserved bit sh[59] is intentionally dropped.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_pbits   <= '0;
      r_lap     <= '0;
      r_eir     <= 1'b0;
      r_sr      <= '0;
      r_sp      <= '0;
      r_uap     <= '0;
      r_nap     <= '0;
      r_cod     <= '0;
      r_lt_addr <= '0;
      r_clk     <= '0;
      r_psm     <= '0;
    end else if (w_commit) begin
      r_pbits   <= r_sh[33:0];
      r_lap     <= r_sh[57:34];
      r_eir     <= r_sh[58];
      r_sr      <= r_sh[61:60];
      r_sp      <= r_sh[63:62];
      r_uap     <= r_sh[71:64];
      r_nap     <= r_sh[87:72];
      r_cod     <= r_sh[111:88];
      r_lt_addr <= r_sh[114:112];
      r_clk     <= r_sh[140:115];
      r_psm     <= r_sh[143:141];
    end
  end

  assign o_fhs_pbits   = r_pbits;
  assign o_fhs_lap     = r_lap;
  assign o_fhs_eir     = r_eir;
  assign o_fhs_sr      = r_sr;
  assign o_fhs_sp      = r_sp;
  assign o_fhs_uap     = r_uap;
  assign o_fhs_nap     = r_nap;
  assign o_fhs_cod     = r_cod;
  assign o_fhs_lt_addr = r_lt_addr;
  assign o_fhs_clk     = r_clk;
  assign o_fhs_psm     = r_psm;
  assign o_fhs_new_p   = r_new_p;
  assign o_fhs_err_p   = r_err_p;
  assign o_fhs_errcode = r_errcode;
  assign o_fhs_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_decfhs_commit.sv
`timescale 1ns/1ps
// Scoreboard bench for decfhs_commit: two instances (keep-last-good and update-on-error)
// share stimulus; per-instance monitors pop expected commit/error events.
module tb_decfhs_commit;
  localparam int P = 10;

  typedef struct packed {
    logic [2:0]  psm;
    logic [25:0] clk;
    logic [2:0]  lt;
    logic [23:0] cod;
    logic [15:0] nap;
    logic [7:0]  uap;
    logic [1:0]  sp;
    logic [1:0]  sr;
    logic        eir;
    logic [23:0] lap;
    logic [33:0] pbits;
  } fhs_t;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    fhs_t       f;
    longint     t;
  } exp_t;

  logic clk_6M = 1'b0;
  logic rstz, st_p, daten, period, valid, dat, rxfhs, crc_done, crc_ok;

  logic [33:0] a_pbits, b_pbits;
  logic [23:0] a_lap, b_lap, a_cod, b_cod;
  logic        a_eir, b_eir, a_new, b_new, a_err, b_err, a_busy, b_busy;
  logic [1:0]  a_sr, b_sr, a_sp, b_sp, a_code, b_code;
  logic [7:0]  a_uap, b_uap;
  logic [15:0] a_nap, b_nap;
  logic [2:0]  a_lt, b_lt, a_psm, b_psm;
  logic [27:2] a_clk, b_clk;
  fhs_t        a_f, b_f;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  fhs_t cur_a, cur_b, p1, p2, p3, p4;

  always #(P/2) clk_6M = ~clk_6M;

  assign a_f = {a_psm, a_clk, a_lt, a_cod, a_nap, a_uap, a_sp, a_sr, a_eir, a_lap, a_pbits};
  assign b_f = {b_psm, b_clk, b_lt, b_cod, b_nap, b_uap, b_sp, b_sr, b_eir, b_lap, b_pbits};

  decfhs_commit #(.CRC_TMO(16), .TMO_W(12), .UPDATE_ON_ERR(1'b0)) u_keep (
    .clk_6M(clk_6M), .rstz(rstz), .i_dec_py_st_p(st_p), .i_daten(daten),
    .i_dec_py_period(period), .i_py_datvalid_p(valid), .i_pydecdatout(dat),
    .i_rxfhs(rxfhs), .i_crc_done_p(crc_done), .i_crc_ok(crc_ok),
    .o_fhs_pbits(a_pbits), .o_fhs_lap(a_lap), .o_fhs_eir(a_eir), .o_fhs_sr(a_sr),
    .o_fhs_sp(a_sp), .o_fhs_uap(a_uap), .o_fhs_nap(a_nap), .o_fhs_cod(a_cod),
    .o_fhs_lt_addr(a_lt), .o_fhs_clk(a_clk), .o_fhs_psm(a_psm), .o_fhs_new_p(a_new),
    .o_fhs_err_p(a_err), .o_fhs_errcode(a_code), .o_fhs_busy(a_busy)
  );

  decfhs_commit #(.CRC_TMO(16), .TMO_W(12), .UPDATE_ON_ERR(1'b1)) u_upd (
    .clk_6M(clk_6M), .rstz(rstz), .i_dec_py_st_p(st_p), .i_daten(daten),
    .i_dec_py_period(period), .i_py_datvalid_p(valid), .i_pydecdatout(dat),
    .i_rxfhs(rxfhs), .i_crc_done_p(crc_done), .i_crc_ok(crc_ok),
    .o_fhs_pbits(b_pbits), .o_fhs_lap(b_lap), .o_fhs_eir(b_eir), .o_fhs_sr(b_sr),
    .o_fhs_sp(b_sp), .o_fhs_uap(b_uap), .o_fhs_nap(b_nap), .o_fhs_cod(b_cod),
    .o_fhs_lt_addr(b_lt), .o_fhs_clk(b_clk), .o_fhs_psm(b_psm), .o_fhs_new_p(b_new),
    .o_fhs_err_p(b_err), .o_fhs_errcode(b_code), .o_fhs_busy(b_busy)
  );

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_evt(input string nm, input exp_t e, input logic newp, input logic errp,
                         input logic [1:0] code, input logic busy, input fhs_t f);
    chk({nm, " kind"}, 160'({newp, errp}), 160'({~e.is_err, e.is_err}));
    chk({nm, " errcode"}, 160'(code), 160'(e.code));
    chk({nm, " busy"}, 160'(busy), 160'(0));
    chk({nm, " fields"}, 160'(f), 160'(e.f));
    if (e.t != 0) chk({nm, " time"}, 160'($time), 160'(e.t));
  endtask

  always @(negedge clk_6M) begin
    if (rstz && (a_new || a_err)) begin
      if (q_a.size() == 0) chk("A unexpected pulse", 160'({a_new, a_err}), 160'(0));
      else begin
        ea = q_a.pop_front();
        chk_evt("A", ea, a_new, a_err, a_code, a_busy, a_f);
      end
    end
  end

  always @(negedge clk_6M) begin
    if (rstz && (b_new || b_err)) begin
      if (q_b.size() == 0) chk("B unexpected pulse", 160'({b_new, b_err}), 160'(0));
      else begin
        eb = q_b.pop_front();
        chk_evt("B", eb, b_new, b_err, b_code, b_busy, b_f);
      end
    end
  end

  // Reserved bit 59 is sent as 1 so a leak into any field is visible.
  function automatic logic [143:0] pkt(input fhs_t f);
    return {f.psm, f.clk, f.lt, f.cod, f.nap, f.uap, f.sp, f.sr, 1'b1, f.eir, f.lap, f.pbits};
  endfunction

  task automatic push(input logic is_err, input logic [1:0] code, input fhs_t fa,
                      input fhs_t fb, input longint t);
    q_a.push_back('{is_err: is_err, code: code, f: fa, t: t});
    q_b.push_back('{is_err: is_err, code: code, f: fb, t: t});
  endtask

  task automatic send_raw(input logic b, input logic fhs, input logic den);
    dat = b; rxfhs = fhs; daten = den; period = 1'b1; valid = 1'b1;
    @(negedge clk_6M);
    valid = 1'b0; daten = 1'b0; period = 1'b0; rxfhs = 1'b0;
  endtask

  task automatic send_bits(input logic [143:0] v, input int n);
    for (int i = 0; i < n; i++) send_raw(v[i], 1'b1, 1'b1);
  endtask

  task automatic start_pkt();
    st_p = 1'b1;
    @(negedge clk_6M);
    st_p = 1'b0;
  endtask

  task automatic crc(input logic ok);
    crc_done = 1'b1; crc_ok = ok;
    @(negedge clk_6M);
    crc_done = 1'b0; crc_ok = 1'b0;
  endtask

  initial begin
    logic [143:0] v;
    longint t_last;
    p1 = '{psm: 3'd2, clk: 26'h2ABCDEF, lt: 3'd3, cod: 24'h240404, nap: 16'h1234, uap: 8'h5A,
           sp: 2'd2, sr: 2'd1, eir: 1'b1, lap: 24'h9E8B33, pbits: 34'h212345678};
    p2 = '{psm: 3'd5, clk: 26'h1555555, lt: 3'd5, cod: 24'h1F0000, nap: 16'h4321, uap: 8'hA5,
           sp: 2'd1, sr: 2'd2, eir: 1'b0, lap: 24'h000001, pbits: 34'h0F0F0F0F0};
    p3 = '{psm: 3'd7, clk: 26'h0000001, lt: 3'd1, cod: 24'hABCDEF, nap: 16'hFFFF, uap: 8'h01,
           sp: 2'd3, sr: 2'd0, eir: 1'b1, lap: 24'hC0FFEE, pbits: 34'h3FFFFFFFF};
    p4 = '{psm: 3'd1, clk: 26'h3000000, lt: 3'd6, cod: 24'h5A5A5A, nap: 16'h0F0F, uap: 8'h81,
           sp: 2'd0, sr: 2'd3, eir: 1'b0, lap: 24'h123456, pbits: 34'h155555555};
    rstz = 1'b0; st_p = 0; daten = 0; period = 0; valid = 0; dat = 0; rxfhs = 0;
    crc_done = 0; crc_ok = 0;
    #3;
    chk("reset fields A", 160'(a_f), 160'(0));
    chk("reset fields B", 160'(b_f), 160'(0));
    chk("reset flags A", 160'({a_new, a_err, a_code, a_busy}), 160'(0));
    @(negedge clk_6M);
    rstz = 1'b1;
    @(negedge clk_6M);

    // Good packet
    start_pkt();
    send_bits(pkt(p1), 144);
    chk("busy in wait", 160'(a_busy), 160'(1));
    push(1'b0, 2'd0, p1, p1, 0);
    crc(1'b1);
    cur_a = p1; cur_b = p1;
    repeat (3) @(negedge clk_6M);

    // Bad CRC: A keeps last good, B loads anyway
    start_pkt();
    send_bits(pkt(p2), 144);
    push(1'b1, 2'd1, cur_a, p2, 0);
    crc(1'b0);
    cur_b = p2;
    repeat (3) @(negedge clk_6M);

    // Short packet with crc_ok=1
    start_pkt();
    send_bits(pkt(p3), 100);
    push(1'b1, 2'd2, cur_a, cur_b, 0);
    crc(1'b1);
    repeat (3) @(negedge clk_6M);

    // CRC timeout: pulse lands 17 cycles after the last-bit edge
    start_pkt();
    v = pkt(p3);
    send_bits(v, 143);
    t_last = longint'($time);
    push(1'b1, 2'd3, cur_a, cur_b, t_last + 18 * P);
    send_raw(v[143], 1'b1, 1'b1);
    repeat (25) @(negedge clk_6M);

    // Restart after 60 bits, then a good packet
    start_pkt();
    send_bits(pkt(p2), 60);
    start_pkt();
    send_bits(pkt(p3), 144);
    push(1'b0, 2'd0, p3, p3, 0);
    crc(1'b1);
    cur_a = p3; cur_b = p3;
    repeat (3) @(negedge clk_6M);

    // Interleaved unqualified bits and 6 surplus bits
    start_pkt();
    v = pkt(p4);
    for (int i = 0; i < 144; i++) begin
      send_raw(v[i], 1'b1, 1'b1);
      if (i % 10 == 3) send_raw(~v[i], 1'b0, 1'b1);
      if (i % 17 == 5) send_raw(~v[i], 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) send_raw(~v[i], 1'b1, 1'b1);
    push(1'b0, 2'd0, p4, p4, 0);
    crc(1'b1);
    cur_a = p4; cur_b = p4;
    repeat (3) @(negedge clk_6M);

    // CRC strobe in IDLE must be ignored
    crc(1'b1);
    crc(1'b0);
    repeat (3) @(negedge clk_6M);
    chk("idle crc fields A", 160'(a_f), 160'(cur_a));

    // rxfhs low for whole packet
    start_pkt();
    for (int i = 0; i < 144; i++) send_raw(1'b1, 1'b0, 1'b1);
    push(1'b1, 2'd2, cur_a, cur_b, 0);
    crc(1'b1);
    repeat (3) @(negedge clk_6M);

    // Async reset mid-SHIFT
    start_pkt();
    send_bits(pkt(p1), 30);
    #2 rstz = 1'b0;
    #1;
    chk("async rst fields A", 160'(a_f), 160'(0));
    chk("async rst fields B", 160'(b_f), 160'(0));
    chk("async rst flags A", 160'({a_new, a_err, a_code, a_busy}), 160'(0));
    chk("async rst flags B", 160'({b_new, b_err, b_code, b_busy}), 160'(0));
    @(negedge clk_6M);
    rstz = 1'b1;
    repeat (3) @(negedge clk_6M);

    chk("A events pending", 160'(q_a.size()), 160'(0));
    chk("B events pending", 160'(q_b.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
